spmv_val_rd_arbiter: RTL and testbench
======================================

Name: spmv_val_rd_arbiter

Overview:
- Shares the single HBM Val read port among NUM_REQ spmv calc kernels.
- Round-robin arbitration on the AR channel, with a registered AR output slot.
- R beats are routed back in order through a requester-ID FIFO; HBM returns bursts in order on the single ID.
- Read-only: kernels never write Val. Replaces the generic crossbar on the Val path.

Parameters:
- NUM_REQ, 4, number of kernel requesters (2..8).
- ADDR_W, 48, AXI address width.
- DATA_W, 256, AXI data width.
- MAX_OUTST, 8, max bursts granted but not completed (power of 2).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- s_arvalid  in  NUM_REQ  per-requester AR valid.
- s_arready  out  NUM_REQ  per-requester AR ready.
- s_araddr  in  NUM_REQ*ADDR_W  packed addresses; requester i occupies slice i.
- s_arlen  in  NUM_REQ*8  burst lengths.
- s_arsize  in  NUM_REQ*3  burst sizes.
- s_arburst  in  NUM_REQ*2  burst types.
- s_rvalid  out  NUM_REQ  per-requester R valid.
- s_rready  in  NUM_REQ  per-requester R ready.
- s_rdata  out  NUM_REQ*DATA_W  broadcast of m_rdata to every slice.
- s_rresp  out  NUM_REQ*2  broadcast of m_rresp.
- s_rlast  out  NUM_REQ  broadcast of m_rlast.
- m_arvalid  out  1  AR valid to HBM.
- m_arready  in  1  AR ready from HBM.
- m_araddr  out  ADDR_W  AR address to HBM.
- m_arlen  out  8  AR length to HBM.
- m_arsize  out  3  AR size to HBM.
- m_arburst  out  2  AR burst type to HBM.
- m_rvalid  in  1  R valid from HBM.
- m_rready  out  1  R ready to HBM.
- m_rdata  in  DATA_W  R data from HBM.
- m_rresp  in  2  R response from HBM.
- m_rlast  in  1  R last from HBM.
- outstanding  out  $clog2(MAX_OUTST)+1  current ID FIFO occupancy.
- err_orphan_r  out  1  sticky flag: m_rvalid seen with ID FIFO empty.

Behaviour:
- Reset:
  - m_arvalid=0; all AR output registers=0.
  - RR pointer=0; FIFO empty; outstanding=0; err_orphan_r=0.
  - All s_arready=0, all s_rvalid=0, m_rready=0.
- Slot free: slot_free = !m_arvalid || m_arready.
- Grant enable: grant_en = slot_free && (outstanding < MAX_OUTST) && (|s_arvalid).
- Winner selection:
  - Winner w = first i with s_arvalid[i], searching from RR pointer p upward with wrap (p, p+1, ..., NUM_REQ-1, 0, ..., p-1).
- Grant handshake:
  - s_arready is combinational: only s_arready[w] is high, and only when grant_en.
  - At most one grant per cycle.
- On grant (clock edge):
  - Output slot loads s_araddr/arlen/arsize/arburst[w]; m_arvalid=1.
  - w is pushed into the ID FIFO.
  - p is set to (w+1) mod NUM_REQ.
- m_arvalid stays high, with stable payload, until m_arready.
- Back-to-back grants are allowed (slot reloads in the same cycle it drains): sustained 1 AR/cycle.
- If m_arready is low with a slot pending, no new grant is made; s_arready stays all 0.
- AR grant latency: requester handshake at cycle N gives m_arvalid high at N+1.
- R routing:
  - h = FIFO head; FIFO is non-empty.
  - s_rvalid[h] = m_rvalid; all other s_rvalid = 0.
  - m_rready = s_rready[h].
- Pop: FIFO pops on m_rvalid && m_rready && m_rlast.
- outstanding:
  - Increments on grant; decrements on pop.
  - On a simultaneous grant and pop, it stays unchanged.
  - A simultaneous push and pop on a full FIFO is legal only because the grant condition is evaluated on the pre-pop count. The FIFO is therefore never over-pushed.
- R with FIFO empty:
  - m_rready=0 (beat stalls indefinitely); err_orphan_r set to 1.
  - err_orphan_r clears only on rst.
- Full FIFO (outstanding==MAX_OUTST): no grants; R path still drains normally.
- Reset mid-burst: all state is cleared in the same cycle. Bursts already in flight are the system's responsibility; HBM is reset together with the arbiter.
- Requester deasserting s_arvalid without a handshake is an AXI violation; no protection is provided.
- Widths: RR pointer and FIFO entries are $clog2(NUM_REQ) bits. FIFO pointers wrap mod MAX_OUTST.

Test Plan:
- Single request: req1 arvalid, addr=0x1000, len=3; m_arready=1 → s_arready[1] high at cycle 0; m_araddr=0x1000 with m_arvalid at cycle 1. Then 4 R beats, last with rlast → all go to s_rvalid[1] only; outstanding returns 0.
- Fairness: all 4 requesters hold arvalid continuously; m_arready=1 → grant order 0,1,2,3,0,1,...; one grant per cycle; no requester is granted twice within any 4 consecutive grants.
- Backpressure on AR: m_arready=0 for 5 cycles with slot full → s_arready all 0. m_araddr and m_arvalid stay stable; when m_arready=1, the next grant happens in that same cycle.
- Outstanding limit: MAX_OUTST=8 grants with no R returned → outstanding=8 and no further s_arready. One burst completes (rlast handshake) → the next grant occurs in the following cycle.
- R backpressure and ordering: grant to req2 (len=1), then req0 (len=0); s_rready[2]=0 for 3 cycles → m_rready=0 during those cycles. req0 receives nothing until req2's rlast beat completes.
- Orphan R: m_rvalid=1 with empty FIFO → m_rready=0, err_orphan_r=1 and held. rst=1 for one cycle → err_orphan_r=0, outstanding=0.

Source files
------------

// File: rtl/spmv_val_rd_arbiter.sv
// Round-robin read arbiter that shares the HBM Val read port among the SpMV calc kernels.
// AR requests are granted into a registered slot; R beats are steered back in order by a requester-ID FIFO.
module spmv_val_rd_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ADDR_W    = 48,
  parameter int DATA_W    = 256,
  parameter int MAX_OUTST = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            s_arvalid,
  output logic [NUM_REQ-1:0]            s_arready,
  input  logic [NUM_REQ*ADDR_W-1:0]     s_araddr,
  input  logic [NUM_REQ*8-1:0]          s_arlen,
  input  logic [NUM_REQ*3-1:0]          s_arsize,
  input  logic [NUM_REQ*2-1:0]          s_arburst,
  output logic [NUM_REQ-1:0]            s_rvalid,
  input  logic [NUM_REQ-1:0]            s_rready,
  output logic [NUM_REQ*DATA_W-1:0]     s_rdata,
  output logic [NUM_REQ*2-1:0]          s_rresp,
  output logic [NUM_REQ-1:0]            s_rlast,
  output logic                          m_arvalid,
  input  logic                          m_arready,
  output logic [ADDR_W-1:0]             m_araddr,
  output logic [7:0]                    m_arlen,
  output logic [2:0]                    m_arsize,
  output logic [1:0]                    m_arburst,
  input  logic                          m_rvalid,
  output logic                          m_rready,
  input  logic [DATA_W-1:0]             m_rdata,
  input  logic [1:0]                    m_rresp,
  input  logic                          m_rlast,
  output logic [$clog2(MAX_OUTST):0]    outstanding,
  output logic                          err_orphan_r
);

  // Handshakes: a transfer happens on a rising clk edge where valid && ready; valid never waits on ready.

  localparam int IDW = $clog2(NUM_REQ);
  localparam int PW  = $clog2(MAX_OUTST);
  localparam int CW  = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(MAX_OUTST);

  logic [IDW-1:0]    r_rr_ptr;
  logic [IDW-1:0]    r_fifo [MAX_OUTST];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              r_arvalid;
  logic [ADDR_W-1:0] r_araddr;
  logic [7:0]        r_arlen;
  logic [2:0]        r_arsize;
  logic [1:0]        r_arburst;
  logic              r_orphan;

  logic              w_slot_free;
  logic              w_grant;
  logic              w_found;
  logic [IDW-1:0]    w_win;
  logic [IDW-1:0]    w_win_next;
  logic              w_nonempty;
  logic [IDW-1:0]    w_head;
  logic              w_pop;

  function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IDW'(s);
  endfunction

  // First requesting index at or after the RR pointer, wrapping around.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_found && s_arvalid[rr_idx(r_rr_ptr, k)]) begin
        w_found = 1'b1;
        w_win   = rr_idx(r_rr_ptr, k);
      end
    end
  end

  assign w_slot_free = !r_arvalid || m_arready;
  assign w_grant     = w_slot_free && (r_count < FULL_CNT) && w_found;
  assign w_win_next  = (w_win == IDW'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
  assign w_nonempty  = (r_count != '0);
  assign w_head      = r_fifo[r_rd_ptr];
  assign w_pop       = m_rvalid && m_rready && m_rlast;

  always_comb begin
    s_arready = '0;
    if (w_grant) s_arready[w_win] = 1'b1;
  end

  always_comb begin
    s_rvalid = '0;
    m_rready = 1'b0;
    if (w_nonempty) begin
      s_rvalid[w_head] = m_rvalid;
      m_rready         = s_rready[w_head];
    end
  end

  assign s_rdata      = {NUM_REQ{m_rdata}};
  assign s_rresp      = {NUM_REQ{m_rresp}};
  assign s_rlast      = {NUM_REQ{m_rlast}};
  assign m_arvalid    = r_arvalid;
  assign m_araddr     = r_araddr;
  assign m_arlen      = r_arlen;
  assign m_arsize     = r_arsize;
  assign m_arburst    = r_arburst;
  assign outstanding  = r_count;
  assign err_orphan_r = r_orphan;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_arvalid <= 1'b0;
      r_araddr  <= '0;
      r_arlen   <= '0;
      r_arsize  <= '0;
      r_arburst <= '0;
      r_rr_ptr  <= '0;
    end else if (w_grant) begin
      r_arvalid <= 1'b1;
      r_araddr  <= s_araddr[int'(w_win)*ADDR_W +: ADDR_W];
      r_arlen   <= s_arlen[int'(w_win)*8 +: 8];
      r_arsize  <= s_arsize[int'(w_win)*3 +: 3];
      r_arburst <= s_arburst[int'(w_win)*2 +: 2];
      r_rr_ptr  <= w_win_next;
    end else if (m_arready) begin
      r_arvalid <= 1'b0;
    end
  end

  // Grant is qualified on the pre-pop count, so push+pop on a full FIFO never overflows.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_orphan <= 1'b0;
    end else begin
      if (w_grant) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_grant, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (m_rvalid && !w_nonempty) r_orphan <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_grant) r_fifo[r_wr_ptr] <= w_win;
  end

endmodule

// File: tb/tb_spmv_val_rd_arbiter.sv
// Directed bench for spmv_val_rd_arbiter: reset, single burst, fairness, limits, R ordering, orphan R.
module tb_spmv_val_rd_arbiter;

  localparam int NR = 4;
  localparam int AW = 48;
  localparam int DW = 256;
  localparam int MO = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   s_arvalid;
  logic [NR-1:0]   s_arready;
  logic [NR*AW-1:0] s_araddr;
  logic [NR*8-1:0] s_arlen;
  logic [NR*3-1:0] s_arsize;
  logic [NR*2-1:0] s_arburst;
  logic [NR-1:0]   s_rvalid;
  logic [NR-1:0]   s_rready;
  logic [NR*DW-1:0] s_rdata;
  logic [NR*2-1:0] s_rresp;
  logic [NR-1:0]   s_rlast;
  logic            m_arvalid;
  logic            m_arready;
  logic [AW-1:0]   m_araddr;
  logic [7:0]      m_arlen;
  logic [2:0]      m_arsize;
  logic [1:0]      m_arburst;
  logic            m_rvalid;
  logic            m_rready;
  logic [DW-1:0]   m_rdata;
  logic [1:0]      m_rresp;
  logic            m_rlast;
  logic [$clog2(MO):0] outstanding;
  logic            err_orphan_r;

  int n_checks = 0;
  int n_err    = 0;

  spmv_val_rd_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTST(MO)) dut (
    .clk(clk), .rst(rst),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
    .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata),
    .s_rresp(s_rresp), .s_rlast(s_rlast),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
    .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata),
    .m_rresp(m_rresp), .m_rlast(m_rlast),
    .outstanding(outstanding), .err_orphan_r(err_orphan_r)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] addr, input logic [7:0] len);
    s_araddr[i*AW +: AW] = addr;
    s_arlen[i*8 +: 8]    = len;
    s_arsize[i*3 +: 3]   = 3'd5;
    s_arburst[i*2 +: 2]  = 2'd1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_arvalid = '0;
    m_rvalid  = 1'b0;
    m_rlast   = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    s_arvalid = '0; s_araddr = '0; s_arlen = '0; s_arsize = '0; s_arburst = '0;
    s_rready = '0; m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
    m_rresp = 2'd0; m_rlast = 1'b0;
    tick(); tick();

    // Reset state
    chk("rst_arvalid", 64'(m_arvalid), 64'd0);
    chk("rst_araddr", 64'(m_araddr), 64'd0);
    chk("rst_outst", 64'(outstanding), 64'd0);
    chk("rst_orphan", 64'(err_orphan_r), 64'd0);
    chk("rst_arready", 64'(s_arready), 64'd0);
    chk("rst_rvalid", 64'(s_rvalid), 64'd0);
    chk("rst_mrready", 64'(m_rready), 64'd0);
    rst = 1'b0;
    tick();

    // Single request from req1, 4-beat burst
    set_req(1, 48'h1000, 8'd3);
    s_arvalid = 4'b0010;
    m_arready = 1'b1;
    settle();
    chk("single_arready", 64'(s_arready), 64'b0010);
    tick();
    s_arvalid = '0;
    settle();
    chk("single_marvalid", 64'(m_arvalid), 64'd1);
    chk("single_maraddr", 64'(m_araddr), 64'h1000);
    chk("single_marlen", 64'(m_arlen), 64'd3);
    chk("single_marsize", 64'(m_arsize), 64'd5);
    chk("single_outst1", 64'(outstanding), 64'd1);
    tick();
    chk("single_drained", 64'(m_arvalid), 64'd0);
    s_rready = 4'b1111;
    m_rvalid = 1'b1;
    for (int b = 0; b < 4; b++) begin
      m_rdata = {4{64'hA5A5_0000_0000_0000 + 64'(b)}};
      m_rlast = (b == 3);
      settle();
      chk("single_rvalid", 64'(s_rvalid), 64'b0010);
      chk("single_rdata", s_rdata[1*DW +: 64], 64'hA5A5_0000_0000_0000 + 64'(b));
      chk("single_mrready", 64'(m_rready), 64'd1);
      tick();
    end
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
    settle();
    chk("single_outst0", 64'(outstanding), 64'd0);

    // Fairness: everyone requests, pointer starts at 0 after reset
    do_reset();
    for (int i = 0; i < NR; i++) set_req(i, 48'h2000 + 48'(i) * 48'h100, 8'd0);
    s_arvalid = 4'b1111;
    m_arready = 1'b1;
    for (int g = 0; g < MO; g++) begin
      settle();
      chk("fair_arready", 64'(s_arready), 64'(1) << (g % NR));
      tick();
      chk("fair_maraddr", 64'(m_araddr), 64'h2000 + 64'(g % NR) * 64'h100);
    end

    // Outstanding limit reached with requests still pending
    settle();
    chk("full_outst", 64'(outstanding), 64'd8);
    chk("full_arready", 64'(s_arready), 64'd0);
    tick();
    chk("full_slot_drained", 64'(m_arvalid), 64'd0);
    chk("full_arready2", 64'(s_arready), 64'd0);
    // Complete head burst (req0, single beat); regrant only after the pop
    m_rvalid = 1'b1;
    m_rlast  = 1'b1;
    s_rready = 4'b1111;
    settle();
    chk("full_r_rvalid", 64'(s_rvalid), 64'b0001);
    chk("full_r_mrready", 64'(m_rready), 64'd1);
    chk("full_r_noarready", 64'(s_arready), 64'd0);
    tick();
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
    settle();
    chk("full_outst7", 64'(outstanding), 64'd7);
    chk("full_regrant", 64'(s_arready), 64'b0001);
    tick();
    chk("full_outst8", 64'(outstanding), 64'd8);

    // AR backpressure: slot held while m_arready is low
    do_reset();
    set_req(0, 48'hABC000, 8'd2);
    set_req(1, 48'h111000, 8'd0);
    set_req(2, 48'h222000, 8'd0);
    m_arready = 1'b0;
    s_arvalid = 4'b0001;
    settle();
    chk("bp_first_arready", 64'(s_arready), 64'b0001);
    tick();
    s_arvalid = 4'b0110;
    for (int c = 0; c < 5; c++) begin
      settle();
      chk("bp_arready", 64'(s_arready), 64'd0);
      chk("bp_marvalid", 64'(m_arvalid), 64'd1);
      chk("bp_maraddr", 64'(m_araddr), 64'hABC000);
      chk("bp_marlen", 64'(m_arlen), 64'd2);
      tick();
    end
    m_arready = 1'b1;
    settle();
    chk("bp_release_arready", 64'(s_arready), 64'b0010);
    tick();
    chk("bp_next_addr", 64'(m_araddr), 64'h111000);
    chk("bp_next_valid", 64'(m_arvalid), 64'd1);
    chk("bp_outst2", 64'(outstanding), 64'd2);
    s_arvalid = 4'b0100;
    settle();
    chk("bp_b2b_arready", 64'(s_arready), 64'b0100);
    tick();
    s_arvalid = '0;
    chk("bp_b2b_addr", 64'(m_araddr), 64'h222000);

    // R backpressure and ordering: req2 (2 beats) then req0 (1 beat)
    do_reset();
    set_req(2, 48'h3000, 8'd1);
    set_req(0, 48'h4000, 8'd0);
    m_arready = 1'b1;
    s_arvalid = 4'b0100;
    tick();
    s_arvalid = 4'b0001;
    settle();
    chk("ord_arready0", 64'(s_arready), 64'b0001);
    tick();
    s_arvalid = '0;
    chk("ord_outst2", 64'(outstanding), 64'd2);
    m_rvalid = 1'b1;
    m_rlast  = 1'b0;
    s_rready = 4'b1011;
    for (int c = 0; c < 3; c++) begin
      settle();
      chk("ord_stall_mrready", 64'(m_rready), 64'd0);
      chk("ord_stall_rvalid", 64'(s_rvalid), 64'b0100);
      tick();
    end
    s_rready = 4'b1111;
    settle();
    chk("ord_beat0_mrready", 64'(m_rready), 64'd1);
    tick();
    m_rlast = 1'b1;
    settle();
    chk("ord_beat1_rvalid", 64'(s_rvalid), 64'b0100);
    tick();
    settle();
    chk("ord_req0_rvalid", 64'(s_rvalid), 64'b0001);
    chk("ord_outst1", 64'(outstanding), 64'd1);
    tick();
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
    settle();
    chk("ord_outst0", 64'(outstanding), 64'd0);

    // Orphan R beat with empty FIFO
    m_rvalid = 1'b1;
    settle();
    chk("orph_mrready", 64'(m_rready), 64'd0);
    chk("orph_rvalid", 64'(s_rvalid), 64'd0);
    tick();
    chk("orph_flag", 64'(err_orphan_r), 64'd1);
    m_rvalid = 1'b0;
    tick();
    chk("orph_sticky", 64'(err_orphan_r), 64'd1);
    do_reset();
    settle();
    chk("orph_cleared", 64'(err_orphan_r), 64'd0);
    chk("orph_outst0", 64'(outstanding), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
